hazard_ctrl: RTL

- Pipeline sequencing controller for the 5-stage MIPS core.
- Sits beside the ID stage. Detects load-use and branch-operand hazards and drives the PC, IF/ID and ID/EX control signals (stall, bubble, flush).
- Also selects the immediate extension mode (sign or zero) for the signExt instance in ID.
- All hazard outputs are combinational from ID/EX/MEM fields plus the FSM state.

---
 rtl/hazard_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Load-use / branch-operand hazard controller for the 5-stage MIPS pipeline.
// Optional macro HAZARD_STATS_EN adds saturating stall/flush event counters.
module hazard_ctrl #(
   parameter int REG_W = 5,
   parameter int OP_W  = 6,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [OP_W-1:0]  id_opcode,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             ex_mem_read,
   input  logic             ex_reg_write,
   input  logic [REG_W-1:0] ex_dst,
   input  logic             mem_mem_read,
   input  logic [REG_W-1:0] mem_dst,
   input  logic             branch_taken,
   input  logic             jump,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic             ext_zero,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic {RUN, HOLD} state_e;

   state_e state_q;
   logic   hcnt_q;
   logic   uses_rt, is_br;
   logic   ex_hit, mem_hit, need1, need2, stall;

   // Unknown opcodes fall to the default arm and decode as harmless.
   always_comb begin
      uses_rt  = 1'b0;
      is_br    = 1'b0;
      ext_zero = 1'b0;
      case (id_opcode)
         OP_W'(6'h00), OP_W'(6'h2B): uses_rt = 1'b1;
         OP_W'(6'h04), OP_W'(6'h05): begin
            uses_rt = 1'b1;
            is_br   = 1'b1;
         end
         OP_W'(6'h0C), OP_W'(6'h0D), OP_W'(6'h0E): ext_zero = 1'b1;
         default: ;
      endcase
   end

   assign ex_hit  = (ex_dst != '0) &&
                    ((ex_dst == id_rs) || ((ex_dst == id_rt) && uses_rt));
   assign mem_hit = (mem_dst != '0) &&
                    ((mem_dst == id_rs) || ((mem_dst == id_rt) && uses_rt));

   assign need2 = is_br && ex_mem_read && ex_hit;
   assign need1 = (ex_mem_read && ex_hit) ||
                  (is_br && ex_reg_write && !ex_mem_read && ex_hit) ||
                  (is_br && mem_mem_read && mem_hit);

   // Reset forces the stalled view so nothing advances while it is held.
   assign stall = !rst_n || (state_q == HOLD) ||
                  ((state_q == RUN) && (need1 || need2));

   assign pc_write    = !stall;
   assign ifid_write  = !stall;
   assign idex_bubble = stall;
   assign ifid_flush  = (branch_taken || jump) && !stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         hcnt_q  <= 1'b0;
      end else begin
         case (state_q)
            RUN: if (need2) begin
               state_q <= HOLD;
               hcnt_q  <= 1'b0;
            end
            HOLD: begin
               hcnt_q <= hcnt_q + 1'b1;
               if (hcnt_q == 1'b0) state_q <= RUN;
            end
            default: state_q <= RUN;
         endcase
      end
   end

`ifdef HAZARD_STATS_EN
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
         if (ifid_flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule
